egress_shaper: RTL and testbench
================================

# egress_shaper

Token-bucket rate shaper that sits directly downstream of the scoreboard FIFO. It drives the FIFO `pop` when the FIFO is non-empty and enough tokens are banked. It registers the popped head word into a one-entry output stage with a valid/ready handshake. This gives the formal and simulation benches a realistic, rate-limited consumer in place of a free-running `pop` input.

## Interface
Parameters:
- `WIDTH`, default 8: data width; matches the FIFO data width.
- `TWID`, default 8: token counter and configuration width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_data` in `WIDTH`: FIFO head word; meaningful only when `!fifo_empty`.
- `fifo_pop` out 1: combinational pop to the FIFO.
- `rate` in `TWID`: tokens added every cycle.
- `burst` in `TWID`: bucket capacity, i.e. the saturation ceiling.
- `cost` in `TWID`: tokens consumed per popped word.
- `out_vld` out 1: output register holds a word.
- `out_rdy` in 1: downstream accepts the word this cycle.
- `out_data` out `WIDTH`: registered word.
- `tokens` out `TWID`: current bucket level.
- `cfg_err` out 1: combinational, `cost > burst`; the shaper can never pop.

## Operation
- **State machine** (`st`), two states:
  - `IDLE`: output register empty.
  - `HOLD`: output register full.
- **Slot free:** `slot_free = (st==IDLE) | out_rdy`.
- **Pop condition:** `fifo_pop = !fifo_empty & slot_free & (tokens >= cost) & !rst`.
- **On pop:**
  - `out_data <= fifo_data`.
  - `st <= HOLD`.
- **On `out_rdy` in `HOLD` without a pop:** `st <= IDLE`. `out_data` holds its last value.
- **In `HOLD` with `!out_rdy`:** `out_data` and `out_vld` are stable. This is a hard handshake rule.
- **Token update, evaluated every cycle:**
  - `t1 = tokens - (fifo_pop ? cost : 0)`; never negative, by the pop condition.
  - `t2 = t1 + rate`, computed at `TWID+1` bits.
  - `tokens <= (t2 > burst) ? burst : t2[TWID-1:0]`.
- **Configuration changes:** `burst` lowered below the current level clamps `tokens` to `burst` on the next edge. `rate`, `burst` and `cost` are sampled live every cycle.
- **`cost == 0`:** pops whenever the FIFO is non-empty and the slot is free.
- **`cfg_err` high:** `fifo_pop` is never asserted. Tokens saturate at `burst`.
- **`fifo_pop` guarantee:** never asserted while `fifo_empty`, so the bench's empty/pop assumption holds by construction.

## Timing
- **Reset values:**
  - `st = IDLE`, `out_vld = 0`, `out_data = 0`, `tokens = 0`.
  - `fifo_pop = 0` while `rst` is high.
- **Reset mid-operation:** asynchronously clears a held word. The word is lost, and the FIFO has already popped it.
- **Latency:** pop in cycle N puts the word on `out_data` with `out_vld = 1` in cycle N+1.
- **Throughput:**
  - One word per cycle when `rate >= cost` and `out_rdy` is held high.
  - Otherwise the long-run average is `rate/cost` words per cycle.
- **Simultaneous `out_rdy` and pop in `HOLD`:** the old word is consumed and the new word is loaded on the same edge. `out_vld` stays 1 with no bubble.
- **Tokens after reset deassertion:** the first token credit is applied on the first edge after `rst` deasserts.
- **Overflow:** token arithmetic at `TWID+1` bits plus the saturation clamp guarantees no wrap-around.

## Structure
- Shared package `egress_shaper_pkg`:
  - `typedef enum logic {IDLE, HOLD} shaper_st_t;`
  - Default constants `SHAPER_TWID = 8` and `SHAPER_WIDTH` (aliased to the FIFO data-width option).
- Sub-module `token_bucket`:
  - Owns the `tokens` register and the saturation arithmetic.
  - Ports: `clk`, `rst`, `consume`, `cost`, `rate`, `burst`, `tokens`, `ok` (`tokens >= cost`).
- Top level holds the FSM, output register and pop logic.
- The output register uses the existing `FF` cell. The enable is the pop and D is `fifo_data`.

## Test plan
- **Reset and ramp:** `rate=2, burst=10, cost=4`, FIFO full of 1,2,3…, `out_rdy=1`.
  - `tokens` reads 0,2,4 on successive edges.
  - First `fifo_pop` occurs in the cycle where `tokens=4`.
  - `out_data=1` the next cycle.
  - Steady state is 1 word every 2 cycles.
- **Saturation:** `rate=7, burst=10, cost=0`, FIFO empty for 5 cycles. `tokens` reads 7,10,10,10; it never wraps.
- **Backpressure:** `cost=0`, `out_rdy=0` after the first word 0xA5.
  - `out_vld=1` and `out_data=0xA5` stay stable.
  - `fifo_pop=0` throughout.
  - When `out_rdy` rises: pop that cycle, new word next cycle, no bubble.
- **Empty guard:** `tokens=burst=10, cost=1`, `fifo_empty=1` for 20 cycles. `fifo_pop` is never 1 and `out_vld` stays 0.
- **Config error:** `cost=12, burst=10`. `cfg_err=1`, and there are no pops for 50 cycles.
- **Async reset mid-hold:** assert `rst` between edges while `out_vld=1`. `out_vld`, `tokens` and `fifo_pop` drop to 0 immediately, without waiting for `clk`.

Source files
------------

// File: rtl/egress_shaper_pkg.sv
// Shared types and default widths for the egress token-bucket shaper.
package egress_shaper_pkg;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} shaper_st_t;

    localparam int SHAPER_TWID       = 8;
    localparam int SHAPER_FIFO_WIDTH = 8;
    localparam int SHAPER_WIDTH      = SHAPER_FIFO_WIDTH;

endpackage

// File: rtl/egress_shaper_token_bucket.sv
// Token bucket: per-cycle credit of `rate`, debit of `cost` on consume,
// saturating at `burst`; arithmetic is one bit wider so it never wraps.
module token_bucket
    import egress_shaper_pkg::*;
#(
    parameter int TWID = SHAPER_TWID
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            consume,
    input  logic [TWID-1:0] cost,
    input  logic [TWID-1:0] rate,
    input  logic [TWID-1:0] burst,
    output logic [TWID-1:0] tokens,
    output logic            ok
);

    logic [TWID-1:0] tokens_r;
    logic [TWID:0]   t1_s;
    logic [TWID:0]   t2_s;
    logic [TWID-1:0] next_s;

    // Next bucket level: debit, credit, then clamp to the live ceiling.
    always_comb begin
        t1_s   = {1'b0, tokens_r} - (consume ? {1'b0, cost} : {(TWID+1){1'b0}});
        t2_s   = t1_s + {1'b0, rate};
        next_s = (t2_s > {1'b0, burst}) ? burst : t2_s[TWID-1:0];
    end

    // Bucket level register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tokens_r <= {TWID{1'b0}};
        end else begin
            tokens_r <= next_s;
        end
    end

    assign tokens = tokens_r;
    assign ok     = (tokens_r >= cost);

endmodule

// File: rtl/egress_shaper.sv
// Rate-limited FIFO consumer: pops the head word when tokens allow and the
// one-entry output stage can take it, then presents it with valid/ready.
module egress_shaper
    import egress_shaper_pkg::*;
#(
    parameter int WIDTH = SHAPER_WIDTH,
    parameter int TWID  = SHAPER_TWID
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_pop,
    input  logic [TWID-1:0]  rate,
    input  logic [TWID-1:0]  burst,
    input  logic [TWID-1:0]  cost,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic [TWID-1:0]  tokens,
    output logic             cfg_err
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_HOLD = HOLD;

    logic [0:0]       st_r;
    logic [WIDTH-1:0] data_r;
    logic             slot_free_s;
    logic             ok_s;
    logic             pop_s;
    logic             cfg_err_s;

    // cfg_err also gates the pop so a just-lowered burst cannot leak a word.
    always_comb begin
        cfg_err_s   = (cost > burst);
        slot_free_s = (st_r == ST_IDLE) ? 1'b1 : out_rdy;
        pop_s       = !fifo_empty && slot_free_s && ok_s && !cfg_err_s && !rst;
    end

    token_bucket #(.TWID(TWID)) u_bucket (
        .clk     (clk),
        .rst     (rst),
        .consume (pop_s),
        .cost    (cost),
        .rate    (rate),
        .burst   (burst),
        .tokens  (tokens),
        .ok      (ok_s)
    );

    // Output-stage occupancy; a pop wins over a drain so there is no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_r <= ST_IDLE;
        end else if (pop_s) begin
            st_r <= ST_HOLD;
        end else if (out_rdy) begin
            st_r <= ST_IDLE;
        end else begin
            st_r <= st_r;
        end
    end

    // Output data register, loaded only on a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {WIDTH{1'b0}};
        end else if (pop_s) begin
            data_r <= fifo_data;
        end else begin
            data_r <= data_r;
        end
    end

    assign fifo_pop = pop_s;
    assign cfg_err  = cfg_err_s;
    assign out_vld  = (st_r == ST_HOLD);
    assign out_data = data_r;

endmodule

// File: tb/tb_egress_shaper.sv
// Self-checking bench for egress_shaper: directed scenarios plus random
// traffic against a token-bucket reference model and a queue-based FIFO.
module tb_egress_shaper;

    localparam int W = 8;
    localparam int T = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_empty;
    logic [W-1:0] fifo_data;
    logic         fifo_pop;
    logic [T-1:0] rate, burst, cost;
    logic         out_vld, out_rdy;
    logic [W-1:0] out_data;
    logic [T-1:0] tokens;
    logic         cfg_err;

    always #5 clk = ~clk;

    egress_shaper #(.WIDTH(W), .TWID(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .rate       (rate),
        .burst      (burst),
        .cost       (cost),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .tokens     (tokens),
        .cfg_err    (cfg_err)
    );

    int unsigned  n_vec = 0;
    int unsigned  n_bad = 0;
    logic [W-1:0] fq[$];
    int           m_tok;
    bit           m_vld;
    int           m_data;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tok  = 0;
        m_vld  = 1'b0;
        m_data = 0;
    endtask

    // One clock: drive at negedge, check just after, advance model at posedge.
    task automatic step(input int r, input int b, input int c, input bit rdy);
        bit e_pop;
        int head;
        @(negedge clk);
        rate       = T'(r);
        burst      = T'(b);
        cost       = T'(c);
        out_rdy    = rdy;
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() == 0) ? '0 : fq[0];
        head       = (fq.size() == 0) ? 0 : int'(fq[0]);
        #1;
        e_pop = !rst && (fq.size() > 0) && (!m_vld || rdy) && (m_tok >= c) && (c <= b);
        check("tokens",   32'(tokens),   32'(m_tok));
        check("out_vld",  32'(out_vld),  32'(m_vld));
        check("out_data", 32'(out_data), 32'(m_data));
        check("fifo_pop", 32'(fifo_pop), 32'(e_pop));
        check("cfg_err",  32'(cfg_err),  32'(c > b));
        @(posedge clk);
        if (fifo_pop && fq.size() > 0) void'(fq.pop_front());
        if (rst) begin
            model_reset();
        end else begin
            m_tok = m_tok - (e_pop ? c : 0) + r;
            if (m_tok > b) m_tok = b;
            if (e_pop) begin
                m_vld  = 1'b1;
                m_data = head;
            end else if (rdy) begin
                m_vld = 1'b0;
            end
        end
    endtask

    initial begin
        int r, b, c;
        rst = 1'b1; out_rdy = 1'b0; rate = '0; burst = '0; cost = '0;
        fifo_empty = 1'b1; fifo_data = '0;
        model_reset();
        step(2, 10, 4, 1'b1);
        step(2, 10, 4, 1'b1);
        #1 rst = 1'b0;

        // Reset and ramp: tokens 0,2,4 then one word every 2 cycles.
        for (int i = 1; i <= 20; i++) fq.push_back(W'(i));
        for (int i = 0; i < 20; i++) step(2, 10, 4, 1'b1);
        fq.delete();

        // Saturation with an empty FIFO.
        for (int i = 0; i < 5; i++) step(7, 10, 0, 1'b1);
        #1 check("sat_tokens", 32'(tokens), 32'd10);

        // Backpressure: first word held stable, then drained without a bubble.
        fq.push_back(8'hA5); fq.push_back(8'h3C); fq.push_back(8'h5A);
        step(7, 10, 0, 1'b1);
        for (int i = 0; i < 6; i++) step(7, 10, 0, 1'b0);
        #1 check("bp_hold_data", 32'(out_data), 32'h0000_00A5);
        for (int i = 0; i < 4; i++) step(7, 10, 0, 1'b1);

        // Empty guard with a full bucket.
        fq.delete();
        for (int i = 0; i < 20; i++) step(5, 10, 1, 1'b1);

        // Configuration error: never pops.
        for (int i = 0; i < 10; i++) fq.push_back(W'($urandom));
        for (int i = 0; i < 50; i++) step(3, 10, 12, 1'b1);
        fq.delete();

        // Asynchronous reset while a word is held.
        fq.push_back(8'h11); fq.push_back(8'h22);
        for (int i = 0; i < 3; i++) step(5, 10, 0, 1'b0);
        #1 check("pre_rst_vld", 32'(out_vld), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_vld",    32'(out_vld),  32'd0);
        check("async_tokens", 32'(tokens),   32'd0);
        check("async_pop",    32'(fifo_pop), 32'd0);
        model_reset();
        step(5, 10, 0, 1'b1);
        #1 rst = 1'b0;
        fq.delete();

        // Random traffic with live configuration changes, including wide rates.
        r = 3; b = 12; c = 5;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 64) == 0 || $urandom_range(0, 99) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    r = $urandom_range(150, 255);
                    b = $urandom_range(200, 255);
                    c = $urandom_range(0, 255);
                end else begin
                    r = $urandom_range(0, 8);
                    b = $urandom_range(0, 20);
                    c = $urandom_range(0, 12);
                end
            end
            if (fq.size() < 16 && $urandom_range(0, 2) != 0) fq.push_back(W'($urandom));
            step(r, b, c, 1'($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
